// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the 32-bit MIPS-like datapath: fetch, decode and
// 3-5 state sequencing with registered control outputs. Optional macro CTRL_ROTATE_EN enables rolv/rorv.
module mc_control_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        aluCond,
  output logic        memToReg,
  output logic        memWrite,
  output logic        branchEnable,
  output logic [4:0]  ALUControl,
  output logic        alu4,
  output logic        alu3,
  output logic        alu2,
  output logic        alu1,
  output logic        alu0,
  output logic        ALUSrc,
  output logic        regDst,
  output logic        regWriteEnable,
  output logic        jump,
  output logic        jumpReg,
  output logic        PCWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        secondRound
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_RWB, S_EXECI, S_IWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JR
  } state_e;

  typedef enum logic [2:0] {
    C_RALU, C_LW, C_SW, C_NORI, C_BLEU, C_JAL, C_JR, C_ILLEGAL
  } iclass_e;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch_en;
    logic [4:0] alu_ctrl;
    logic       reg_dst;
    logic       reg_we;
    logic       jump;
    logic       jump_reg;
    logic       pc_write;
    logic       iord;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       second_round;
  } ctrl_t;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_NOR  = 5'b00010;
  localparam logic [4:0] ALU_NOT  = 5'b00011;
  localparam logic [4:0] ALU_ROL  = 5'b00100;
  localparam logic [4:0] ALU_ROR  = 5'b00101;
  localparam logic [4:0] ALU_BLEU = 5'b00110;

  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_BRCH = 2'b11;

  state_e  state_q, state_d;
  ctrl_t   ctrl_q, ctrl_d;
  logic    started_q, started_d;
  iclass_e iclass;
  logic [4:0] r_alu_op;

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  // Instruction classification; only meaningful while instr holds the IR.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    iclass   = C_ILLEGAL;
    r_alu_op = ALU_ADD;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: begin iclass = C_RALU; r_alu_op = ALU_ADD; end
          6'b100100: begin iclass = C_RALU; r_alu_op = ALU_AND; end
          6'b100111: begin iclass = C_RALU; r_alu_op = ALU_NOR; end
          6'b100110: begin iclass = C_RALU; r_alu_op = ALU_NOT; end
`ifdef CTRL_ROTATE_EN
          6'b000100: begin iclass = C_RALU; r_alu_op = ALU_ROL; end
          6'b000110: begin iclass = C_RALU; r_alu_op = ALU_ROR; end
`endif
          6'b001000: iclass = C_JR;
          default:   iclass = C_ILLEGAL;
        endcase
      end
      6'b100011: iclass = C_LW;
      6'b101011: iclass = C_SW;
      6'b001101: iclass = C_NORI;
      6'b000111: iclass = C_BLEU;
      6'b000011: iclass = C_JAL;
      default:   iclass = C_ILLEGAL;
    endcase
  end

  // Control word for a state; the outputs are registered alongside the state,
  // so this is evaluated on the state being entered.
  function automatic ctrl_t state_ctrl(input state_e s, input logic [4:0] exec_op);
    ctrl_t c;
    c = '0;
    c.second_round = (s != S_FETCH);
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_ctrl  = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
        c.pc_write  = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RD2;
        c.alu_ctrl  = exec_op;
      end
      S_RWB: begin
        c.reg_dst = 1'b1;
        c.reg_we  = 1'b1;
      end
      S_EXECI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_NOR;
      end
      S_IWB:    c.reg_we = 1'b1;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_we     = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      // PCWrite for a branch depends on this cycle's compare and is gated at the output.
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RD2;
        c.alu_ctrl  = ALU_BLEU;
        c.branch_en = 1'b1;
        c.pc_src    = PCSRC_BRCH;
      end
      S_JUMP: begin
        c.jump     = 1'b1;
        c.pc_src   = PCSRC_JMP;
        c.pc_write = 1'b1;
        c.reg_we   = 1'b1;
      end
      S_JR: begin
        c.jump_reg = 1'b1;
        c.pc_src   = PCSRC_JMP;
        c.pc_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    started_d = 1'b1;
    state_d   = state_q;
    if (!started_q) begin
      // First edge after reset only raises the FETCH controls.
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (iclass)
            C_RALU:  state_d = S_EXEC;
            C_LW,
            C_SW:    state_d = S_MEMADR;
            C_NORI:  state_d = S_EXECI;
            C_BLEU:  state_d = S_BRANCH;
            C_JAL:   state_d = S_JUMP;
            C_JR:    state_d = S_JR;
            default: state_d = S_FETCH;
          endcase
        end
        S_EXEC:   state_d = S_RWB;
        S_EXECI:  state_d = S_IWB;
        S_MEMADR: state_d = (iclass == C_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_d = S_MEMWB;
        default:  state_d = S_FETCH;
      endcase
    end
    ctrl_d = state_ctrl(state_d, r_alu_op);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the control word is reset too, so every enable drops the moment
      // reset_n falls and an in-flight write is aborted.
      state_q   <= S_FETCH;
      ctrl_q    <= '0;
      started_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so all state flops update together from this edge's values.
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      started_q <= started_d;
    end
  end

  assign memToReg       = ctrl_q.mem_to_reg;
  assign memWrite       = ctrl_q.mem_write;
  assign branchEnable   = ctrl_q.branch_en;
  assign ALUControl     = ctrl_q.alu_ctrl;
  assign {alu4, alu3, alu2, alu1, alu0} = ctrl_q.alu_ctrl;
  assign ALUSrc         = (ctrl_q.alu_src_b == SRCB_IMM);
  assign regDst         = ctrl_q.reg_dst;
  assign regWriteEnable = ctrl_q.reg_we;
  assign jump           = ctrl_q.jump;
  assign jumpReg        = ctrl_q.jump_reg;
  assign PCWrite        = ctrl_q.pc_write | (ctrl_q.branch_en & aluCond);
  assign IorD           = ctrl_q.iord;
  assign IRWrite        = ctrl_q.ir_write;
  assign ALUSrcA        = ctrl_q.alu_src_a;
  assign ALUSrcB        = ctrl_q.alu_src_b;
  assign PCSrc          = ctrl_q.pc_src;
  assign secondRound    = ctrl_q.second_round;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed, table-driven bench for mc_control_unit: per-cycle control vectors
// for every instruction class plus hand-written reset-abort sequences.
module tb_mc_control_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        aluCond;
  logic        memToReg, memWrite, branchEnable;
  logic [4:0]  ALUControl;
  logic        alu4, alu3, alu2, alu1, alu0;
  logic        ALUSrc, regDst, regWriteEnable, jump, jumpReg, PCWrite;
  logic        IorD, IRWrite, ALUSrcA, secondRound;
  logic [1:0]  ALUSrcB, PCSrc;

  mc_control_unit dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .aluCond(aluCond),
    .memToReg(memToReg), .memWrite(memWrite), .branchEnable(branchEnable),
    .ALUControl(ALUControl), .alu4(alu4), .alu3(alu3), .alu2(alu2),
    .alu1(alu1), .alu0(alu0), .ALUSrc(ALUSrc), .regDst(regDst),
    .regWriteEnable(regWriteEnable), .jump(jump), .jumpReg(jumpReg),
    .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .secondRound(secondRound)
  );

  always #5 clock = ~clock;

  typedef enum {
    T_FETCH, T_DECODE, T_EXEC, T_RWB, T_EXECI, T_IWB, T_MEMADR,
    T_MEMRD, T_MEMWB, T_MEMWR, T_BRANCH, T_JUMP, T_JR
  } tstate_e;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch_en;
    logic [4:0] alu_ctrl;
    logic [4:0] alu_bits;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_we;
    logic       jump;
    logic       jump_reg;
    logic       pc_write;
    logic       iord;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       second_round;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        cond;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_AND  = 32'h0022_1824;
  localparam logic [31:0] I_NOR  = 32'h0022_1827;
  localparam logic [31:0] I_NOT  = 32'h0022_1826;
  localparam logic [31:0] I_ROLV = 32'h0022_1804;
  localparam logic [31:0] I_RORV = 32'h0022_1806;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_NORI = 32'h3422_FFFF;
  localparam logic [31:0] I_BLEU = 32'h1C22_0003;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_BADOP = 32'hFC00_0000;
  localparam logic [31:0] I_BADFN = 32'h0022_182A;

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  // Expected control values for a state, written out from the state table.
  function automatic outs_t exp_of(tstate_e s, logic [4:0] alu, logic cond);
    outs_t e;
    e = '0;
    e.second_round = (s != T_FETCH);
    case (s)
      T_FETCH:  begin e.ir_write = 1; e.alu_src_b = 2'b01; e.pc_write = 1; end
      T_EXEC:   begin e.alu_src_a = 1; e.alu_ctrl = alu; end
      T_RWB:    begin e.reg_dst = 1; e.reg_we = 1; end
      T_EXECI:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_src = 1; e.alu_ctrl = 5'b00010; end
      T_IWB:    e.reg_we = 1;
      T_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_src = 1; end
      T_MEMRD:  e.iord = 1;
      T_MEMWB:  begin e.mem_to_reg = 1; e.reg_we = 1; end
      T_MEMWR:  begin e.iord = 1; e.mem_write = 1; end
      T_BRANCH: begin
        e.alu_src_a = 1; e.alu_ctrl = 5'b00110; e.branch_en = 1;
        e.pc_src = 2'b11; e.pc_write = cond;
      end
      T_JUMP:   begin e.jump = 1; e.pc_src = 2'b10; e.pc_write = 1; e.reg_we = 1; end
      T_JR:     begin e.jump_reg = 1; e.pc_src = 2'b10; e.pc_write = 1; end
      default: ;
    endcase
    e.alu_bits = e.alu_ctrl;
    return e;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.mem_to_reg   = memToReg;
    a.mem_write    = memWrite;
    a.branch_en    = branchEnable;
    a.alu_ctrl     = ALUControl;
    a.alu_bits     = {alu4, alu3, alu2, alu1, alu0};
    a.alu_src      = ALUSrc;
    a.reg_dst      = regDst;
    a.reg_we       = regWriteEnable;
    a.jump         = jump;
    a.jump_reg     = jumpReg;
    a.pc_write     = PCWrite;
    a.iord         = IorD;
    a.ir_write     = IRWrite;
    a.alu_src_a    = ALUSrcA;
    a.alu_src_b    = ALUSrcB;
    a.pc_src       = PCSrc;
    a.second_round = secondRound;
    return a;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] i, input logic c,
                     input tstate_e s, input logic [4:0] alu);
    vec_t v;
    v.name  = n;
    v.instr = i;
    v.cond  = c;
    v.exp   = exp_of(s, alu, c);
    vecs.push_back(v);
  endtask

  task automatic add_rtype(input string n, input logic [31:0] i, input logic [4:0] alu);
    add({n, "_decode"}, i, 0, T_DECODE, 0);
    add({n, "_exec"},   i, 0, T_EXEC,   alu);
    add({n, "_rwb"},    i, 0, T_RWB,    0);
    add({n, "_fetch"},  i, 0, T_FETCH,  0);
  endtask

  task automatic add_illegal(input string n, input logic [31:0] i);
    add({n, "_decode"}, i, 0, T_DECODE, 0);
    add({n, "_fetch"},  i, 0, T_FETCH,  0);
  endtask

  initial begin
    reset_n = 1'b0;
    instr   = 32'h0;
    aluCond = 1'b0;

    add("boot_fetch", I_ADD, 0, T_FETCH, 0);
    add_rtype("add", I_ADD, 5'b00000);
    add_rtype("and", I_AND, 5'b00001);
    add_rtype("nor", I_NOR, 5'b00010);
    add_rtype("not", I_NOT, 5'b00011);
`ifdef CTRL_ROTATE_EN
    add_rtype("rolv", I_ROLV, 5'b00100);
    add_rtype("rorv", I_RORV, 5'b00101);
`else
    add_illegal("rolv", I_ROLV);
    add_illegal("rorv", I_RORV);
`endif
    add("lw_decode", I_LW, 0, T_DECODE, 0);
    add("lw_memadr", I_LW, 0, T_MEMADR, 0);
    add("lw_memrd",  I_LW, 0, T_MEMRD,  0);
    add("lw_memwb",  I_LW, 0, T_MEMWB,  0);
    add("lw_fetch",  I_LW, 0, T_FETCH,  0);
    add("sw_decode", I_SW, 0, T_DECODE, 0);
    add("sw_memadr", I_SW, 0, T_MEMADR, 0);
    add("sw_memwr",  I_SW, 0, T_MEMWR,  0);
    add("sw_fetch",  I_SW, 0, T_FETCH,  0);
    add("nori_decode", I_NORI, 0, T_DECODE, 0);
    add("nori_execi",  I_NORI, 0, T_EXECI,  0);
    add("nori_iwb",    I_NORI, 0, T_IWB,    0);
    add("nori_fetch",  I_NORI, 0, T_FETCH,  0);
    add("bleu1_decode", I_BLEU, 0, T_DECODE, 0);
    add("bleu1_branch", I_BLEU, 1, T_BRANCH, 0);
    add("bleu1_fetch",  I_BLEU, 0, T_FETCH,  0);
    add("bleu0_decode", I_BLEU, 1, T_DECODE, 0);
    add("bleu0_branch", I_BLEU, 0, T_BRANCH, 0);
    add("bleu0_fetch",  I_BLEU, 0, T_FETCH,  0);
    add("jal_decode", I_JAL, 0, T_DECODE, 0);
    add("jal_jump",   I_JAL, 0, T_JUMP,   0);
    add("jal_fetch",  I_JAL, 0, T_FETCH,  0);
    add("jr_decode",  I_JR,  0, T_DECODE, 0);
    add("jr_jr",      I_JR,  0, T_JR,     0);
    add("jr_fetch",   I_JR,  0, T_FETCH,  0);
    add_illegal("badop", I_BADOP);
    add_illegal("badfn", I_BADFN);

    repeat (3) @(negedge clock);
    check("reset_outputs", actual(), '0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      instr   = vecs[k].instr;
      aluCond = vecs[k].cond;
      @(posedge clock);
      @(negedge clock);
      check(vecs[k].name, actual(), vecs[k].exp);
    end

    // Branch PCWrite follows aluCond within the BRANCH cycle.
    instr   = I_BLEU;
    aluCond = 1'b0;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    check("bleu_live_cond0", actual(), exp_of(T_BRANCH, 0, 0));
    aluCond = 1'b1;
    #1;
    check("bleu_live_cond1", actual(), exp_of(T_BRANCH, 0, 1));
    aluCond = 1'b0;
    @(posedge clock); @(negedge clock);
    check("bleu_live_fetch", actual(), exp_of(T_FETCH, 0, 0));

    // Reset asserted during MEMWR aborts the store immediately.
    instr = I_SW;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("abort_memwr_before", actual(), exp_of(T_MEMWR, 0, 0));
    #2 reset_n = 1'b0;
    #1;
    check("abort_memwr_async", actual(), '0);
    @(posedge clock); @(negedge clock);
    check("abort_held_in_reset", actual(), '0);
    reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    check("abort_resume_fetch", actual(), exp_of(T_FETCH, 0, 0));
    @(posedge clock); @(negedge clock);
    check("abort_resume_decode", actual(), exp_of(T_DECODE, 0, 0));

    // Reset during JUMP suppresses the link write and PC update.
    instr = I_JAL;
    @(posedge clock); @(negedge clock);
    check("abort_jump_before", actual(), exp_of(T_JUMP, 0, 0));
    #2 reset_n = 1'b0;
    #1;
    check("abort_jump_async", actual(), '0);
    #4 reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    check("abort_jump_fetch", actual(), exp_of(T_FETCH, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
